// File: rtl/nested_loop_sequencer.sv
// rtl/nested_loop_sequencer.sv - two-level (i, j) iteration sequencer with break point and stall
module nested_loop_sequencer #(
   parameter int IDX_W = 2,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_start,
   input  logic [IDX_W-1:0] in_outer_limit,
   input  logic [IDX_W-1:0] in_inner_limit,
   input  logic             in_break_en,
   input  logic [IDX_W-1:0] in_break_i,
   input  logic [IDX_W-1:0] in_break_j,
   input  logic             in_stall,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_i,
   output logic [IDX_W-1:0] out_j,
   output logic             out_busy,
   output logic             out_done,
   output logic [CNT_W-1:0] out_count,
   output logic             out_broke
);

   typedef enum logic [1:0] {IDLE, OUTER, INNER, DONE} state_t;

   state_t           state_q;
   logic [IDX_W-1:0] i_q, j_q;
   logic [IDX_W-1:0] outer_lim_q, inner_lim_q;
   logic             break_en_q;
   logic [IDX_W-1:0] break_i_q, break_j_q;
   logic [CNT_W-1:0] count_q;
   logic             broke_q;

   logic inner_end, break_hit, issue;

   // Priority inside INNER: end of row, then break point, then stall, then issue.
   assign inner_end = (j_q >= inner_lim_q);
   assign break_hit = break_en_q && (i_q == break_i_q) && (j_q == break_j_q);
   assign issue     = (state_q == INNER) && !inner_end && !break_hit && !in_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         i_q         <= '0;
         j_q         <= '0;
         outer_lim_q <= '0;
         inner_lim_q <= '0;
         break_en_q  <= 1'b0;
         break_i_q   <= '0;
         break_j_q   <= '0;
         count_q     <= '0;
         broke_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_start) begin
                  outer_lim_q <= in_outer_limit;
                  inner_lim_q <= in_inner_limit;
                  break_en_q  <= in_break_en;
                  break_i_q   <= in_break_i;
                  break_j_q   <= in_break_j;
                  count_q     <= '0;
                  broke_q     <= 1'b0;
                  i_q         <= '0;
                  j_q         <= '0;
                  state_q     <= OUTER;
               end
            end
            OUTER: begin
               if (i_q < outer_lim_q) begin
                  j_q     <= '0;
                  state_q <= INNER;
               end else begin
                  state_q <= DONE;
               end
            end
            INNER: begin
               if (inner_end) begin
                  i_q     <= i_q + 1'b1;
                  state_q <= OUTER;
               end else if (break_hit) begin
                  broke_q <= 1'b1;
                  i_q     <= i_q + 1'b1;
                  state_q <= OUTER;
               end else if (!in_stall) begin
                  count_q <= count_q + 1'b1;
                  j_q     <= j_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = issue;
   assign out_i     = i_q;
   assign out_j     = j_q;
   assign out_busy  = (state_q != IDLE);
   assign out_done  = (state_q == DONE);
   assign out_count = count_q;
   assign out_broke = broke_q;

endmodule

// File: doc/nested_loop_sequencer.md
Name: nested_loop_sequencer

Overview:
- Clocked controller that walks a two-level (outer i, inner j) iteration space, one inner iteration per cycle.
- Issues one (i, j) index pair per cycle to a downstream datapath.
- Supports a programmable break point that terminates the current inner loop early.
- Sequential counterpart of the combinational nested-loop-with-break counter blocks; sits between a start/done command interface and the per-iteration datapath.

Parameters:
- IDX_W, 2, width of loop indices and limits.
- CNT_W, 4, width of issued-iteration counter; must be >= 2*IDX_W, so the counter never wraps.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_start  input  1  start request; sampled only in IDLE.
- in_outer_limit  input  IDX_W  outer trip count; latched at start.
- in_inner_limit  input  IDX_W  inner trip count; latched at start.
- in_break_en  input  1  enable break point; latched at start.
- in_break_i  input  IDX_W  break outer index; latched at start.
- in_break_j  input  IDX_W  break inner index; latched at start.
- in_stall  input  1  downstream not ready; holds issue in INNER.
- out_valid  output  1  (out_i, out_j) issued this cycle.
- out_i  output  IDX_W  current outer index.
- out_j  output  IDX_W  current inner index.
- out_busy  output  1  high in any state except IDLE.
- out_done  output  1  one-cycle pulse on run completion.
- out_count  output  CNT_W  iterations issued this run.
- out_broke  output  1  a break fired during this run.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - All outputs 0; i, j and the latched config are 0.
  - Reset mid-run aborts the run immediately, with no done pulse.
- IDLE:
  - in_start=1 latches the limits and break config, clears out_count, out_broke, i and j, then goes to OUTER.
  - in_start is ignored in every other state.
- OUTER (1 cycle):
  - If i < outer_lim: j = 0, go to INNER.
  - Else go to DONE.
- INNER, evaluated in priority order each cycle:
  1. j >= inner_lim: i = i+1, go to OUTER; out_valid = 0.
  2. break_en && i == break_i && j == break_j: out_broke = 1, i = i+1, go to OUTER. No issue, and the break iteration is not counted.
  3. in_stall = 1: hold state, i and j; out_valid = 0.
  4. Otherwise: out_valid = 1 with out_i = i and out_j = j (combinational from the current registers); out_count += 1 and j += 1 at the clock edge.
- DONE (1 cycle):
  - out_done = 1, then go to IDLE.
  - out_count and out_broke hold until the next accepted start.
- Arithmetic:
  - Comparisons are unsigned.
  - i and j never exceed their limit, so no index overflow.
- Latency, no stalls and no break: O + O*(I+1) + 2 cycles from the start-sample cycle to the done pulse, where O and I are the outer and inner limits.
- Zero limits:
  - outer_lim = 0: OUTER then DONE, count 0.
  - inner_lim = 0: each outer pass costs 2 cycles and issues nothing.
- Break point outside the iteration space: never fires; out_broke stays 0.
- out_busy is 0 only in IDLE.

Test Plan:
- outer=2, inner=2, break off -> pairs (0,0),(0,1),(1,0),(1,1); out_count=4; out_done at cycle 10 after start; out_broke=0.
- outer=2, inner=2, break at (1,1) -> pairs (0,0),(0,1),(1,0); out_count=3; out_broke=1.
- outer=3, inner=3, break at (1,1) -> 7 issues, with (1,1) and (1,2) skipped; out_count=7; then a start with outer=0 -> done 2 cycles after start, out_count=0.
- outer=3, inner=3, in_stall high for 3 cycles on (0,1) -> out_valid low during the stall, (0,1) issued once afterwards, out_count=9, done delayed by exactly 3 cycles.
- Pulse in_start while busy -> ignored; the running sequence and the latched limits are unchanged.
- Assert rst_n low during INNER at (1,0) -> all outputs 0 asynchronously, no out_done pulse; a fresh start after release runs normally.
